// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: LDM/STM block-transfer sequencer. Takes over the memory and
// register-file ports, issues one word access per listed register in
// ascending register order, then the optional base writeback, and holds the
// pipeline for the whole run.
module ldm_stm_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_reg_list,
  input  logic [3:0]  i_rn_code,
  input  logic [31:0] i_base,
  input  logic        i_p,
  input  logic        i_u,
  input  logic        i_w,
  input  logic        i_l,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [3:0]  o_rf_raddr,
  input  logic [31:0] i_rf_rdata,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_ldm_hold,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [3:0]  rn_q, rn_d;
  logic        l_q, l_d;
  logic        wb_en_q, wb_en_d;

  logic [4:0]  reg_cnt;
  logic [6:0]  offset;
  logic [31:0] offset_w;
  logic [31:0] start_addr;
  logic [3:0]  cur_reg;
  logic [15:0] mask_rest;
  logic        last_xfer;

  // Number of listed registers; the byte span 4n needs 7 bits (max 64)
  always_comb begin
    reg_cnt = 5'd0;
    for (int k = 0; k < 16; k++) begin
      reg_cnt = reg_cnt + {4'd0, i_reg_list[k]};
    end
  end

  assign offset   = {reg_cnt, 2'b00};
  assign offset_w = {25'd0, offset};

  // First access address for the four addressing modes (IA/IB/DA/DB)
  always_comb begin
    case ({i_p, i_u})
      2'b01:   start_addr = i_base;
      2'b11:   start_addr = i_base + 32'd4;
      2'b00:   start_addr = i_base - offset_w + 32'd4;
      default: start_addr = i_base - offset_w;
    endcase
  end

  // Current register is the lowest set bit still pending in the mask
  always_comb begin
    cur_reg = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (mask_q[k]) cur_reg = k[3:0];
    end
  end

  // Clearing the lowest set bit tells us whether this access is the last one
  assign mask_rest = mask_q & (mask_q - 16'd1);
  assign last_xfer = (mask_rest == 16'd0);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mask_q   <= 16'd0;
      addr_q   <= 32'd0;
      wb_val_q <= 32'd0;
      rn_q     <= 4'd0;
      l_q      <= 1'b0;
      wb_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wb_val_q <= wb_val_d;
      rn_q     <= rn_d;
      l_q      <= l_d;
      wb_en_q  <= wb_en_d;
    end
  end

  // Next-state logic; start is only looked at while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = (reg_cnt != 5'd0) ? XFER : DONE;
      XFER: if (i_mem_ack && last_xfer) state_d = wb_en_q ? WB : DONE;
      WB:   state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch the operation on start, advance on each ack
  always_comb begin
    mask_d   = mask_q;
    addr_d   = addr_q;
    wb_val_d = wb_val_q;
    rn_d     = rn_q;
    l_d      = l_q;
    wb_en_d  = wb_en_q;
    if (state_q == IDLE && i_start) begin
      mask_d   = i_reg_list;
      addr_d   = start_addr;
      wb_val_d = i_u ? (i_base + offset_w) : (i_base - offset_w);
      rn_d     = i_rn_code;
      l_d      = i_l;
      // A load that includes the base wins over the writeback
      wb_en_d  = i_w & ~(i_l & i_reg_list[i_rn_code]);
    end else if (state_q == XFER && i_mem_ack) begin
      mask_d = mask_rest;
      addr_d = addr_q + 32'd4;
    end
  end

  // Store data is the register file read port, passed straight through
  assign o_mem_wdata = i_rf_rdata;

  // Output decode: memory access in XFER, RF writes on load acks and in WB
  always_comb begin
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = 32'd0;
    o_rf_raddr = 4'd0;
    o_rf_we    = 1'b0;
    o_rf_waddr = 4'd0;
    o_rf_wdata = 32'd0;
    o_done     = 1'b0;
    o_ldm_hold = 1'b0;
    case (state_q)
      IDLE: o_ldm_hold = i_start;
      XFER: begin
        o_ldm_hold = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_we   = ~l_q;
        o_mem_addr = addr_q;
        o_rf_raddr = cur_reg;
        if (l_q && i_mem_ack) begin
          o_rf_we    = 1'b1;
          o_rf_waddr = cur_reg;
          o_rf_wdata = i_mem_rdata;
        end
      end
      WB: begin
        o_ldm_hold = 1'b1;
        o_rf_we    = 1'b1;
        o_rf_waddr = rn_q;
        o_rf_wdata = wb_val_q;
      end
      DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: directed scoreboard bench for the LDM/STM sequencer.
module tb_ldm_stm_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [15:0] i_reg_list;
  logic [3:0]  i_rn_code;
  logic [31:0] i_base;
  logic        i_p, i_u, i_w, i_l;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [3:0]  o_rf_raddr;
  logic [31:0] i_rf_rdata;
  logic        o_rf_we;
  logic [3:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_ldm_hold, o_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          kind;   // 0 = memory access, 1 = RF write, 2 = done pulse
    int          cyc;    // cycle relative to start acceptance
    logic [31:0] addr;
    logic        we;
    logic [3:0]  rg;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];

  always #5 i_clk = ~i_clk;

  // Register file and memory contents seen by the sequencer
  function automatic logic [31:0] rf_val(input logic [3:0] k);
    return 32'hC0DE_0000 | ({28'd0, k} * 32'h111);
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  assign i_rf_rdata  = rf_val(o_rf_raddr);
  assign i_mem_rdata = mem_fn(o_mem_addr);

  ldm_stm_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_reg_list(i_reg_list), .i_rn_code(i_rn_code), .i_base(i_base),
    .i_p(i_p), .i_u(i_u), .i_w(i_w), .i_l(i_l),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata), .o_rf_we(o_rf_we),
    .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_ldm_hold(o_ldm_hold), .o_done(o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   {31'd0, o_mem_req}, 32'd0);
    check({tag, "_we"},    {31'd0, o_mem_we}, 32'd0);
    check({tag, "_addr"},  o_mem_addr, 32'd0);
    check({tag, "_raddr"}, {28'd0, o_rf_raddr}, 32'd0);
    check({tag, "_rfwe"},  {31'd0, o_rf_we}, 32'd0);
    check({tag, "_waddr"}, {28'd0, o_rf_waddr}, 32'd0);
    check({tag, "_wdata"}, o_rf_wdata, 32'd0);
    check({tag, "_hold"},  {31'd0, o_ldm_hold}, 32'd0);
    check({tag, "_done"},  {31'd0, o_done}, 32'd0);
  endtask

  // Runs one block transfer: builds the expected event list, starts the
  // operation, then compares every DUT event against the scoreboard.
  task automatic run_op(input string name, input logic [15:0] list, input logic [3:0] rn,
                        input logic [31:0] base, input logic p, input logic u,
                        input logic w, input logic l, input int stall, input bit ign_start);
    int n, j, last, done_rel;
    logic [31:0] off, start, a;
    bit wb;
    ev_t e;
    n = 0;
    for (int k = 0; k < 16; k++) if (list[k]) n++;
    off = 32'(4 * n);
    case ({p, u})
      2'b01:   start = base;
      2'b11:   start = base + 32'd4;
      2'b00:   start = base - off + 32'd4;
      default: start = base - off;
    endcase
    j = 0;
    for (int k = 0; k < 16; k++) begin
      if (list[k]) begin
        a = start + 32'(4 * j);
        e = '{kind: 0, cyc: 1 + j + stall, addr: a, we: ~l, rg: 4'(k), data: rf_val(4'(k))};
        sb.push_back(e);
        if (l) begin
          e = '{kind: 1, cyc: 1 + j + stall, addr: 32'd0, we: 1'b0, rg: 4'(k), data: mem_fn(a)};
          sb.push_back(e);
        end
        j++;
      end
    end
    wb   = w && !(l && list[rn]);
    last = (n > 0) ? n + stall : 0;
    if (wb && n > 0) begin
      last++;
      e = '{kind: 1, cyc: last, addr: 32'd0, we: 1'b0, rg: rn, data: u ? base + off : base - off};
      sb.push_back(e);
    end
    done_rel = last + 1;
    e = '{kind: 2, cyc: done_rel, addr: 32'd0, we: 1'b0, rg: 4'd0, data: 32'd0};
    sb.push_back(e);

    @(negedge i_clk);
    i_start = 1'b1; i_reg_list = list; i_rn_code = rn; i_base = base;
    i_p = p; i_u = u; i_w = w; i_l = l; i_mem_ack = 1'b1;
    #1;
    check({name, "_holdT"}, {31'd0, o_ldm_hold}, 32'd1);
    check({name, "_reqT"},  {31'd0, o_mem_req}, 32'd0);
    $display("%s: start list=%h rn=%0d base=%h p=%0b u=%0b w=%0b l=%0b, %0d events expected",
             name, list, rn, base, p, u, w, l, sb.size());

    for (int rel = 1; rel <= done_rel + 1; rel++) begin
      @(negedge i_clk);
      i_start   = ign_start && (rel <= done_rel);
      if (ign_start) begin
        i_reg_list = 16'hFFFF; i_base = 32'hDEAD_BEEF; i_l = ~l; i_w = 1'b1;
      end
      i_mem_ack = (rel <= stall) ? 1'b0 : 1'b1;
      #1;
      check({name, "_hold"}, {31'd0, o_ldm_hold}, {31'd0, rel < done_rel});
      if (o_mem_req) begin
        if (sb.size() == 0 || sb[0].kind != 0) begin
          check({name, "_unexp_req"}, {31'd0, o_mem_req}, 32'd0);
        end else begin
          check({name, "_addr"},  o_mem_addr, sb[0].addr);
          check({name, "_memwe"}, {31'd0, o_mem_we}, {31'd0, sb[0].we});
          check({name, "_raddr"}, {28'd0, o_rf_raddr}, {28'd0, sb[0].rg});
          if (sb[0].we) check({name, "_wdata"}, o_mem_wdata, sb[0].data);
          if (i_mem_ack) begin
            check({name, "_memcyc"}, rel, sb[0].cyc);
            $display("%s: T+%0d mem addr=%h we=%0b reg=%0d", name, rel, o_mem_addr, o_mem_we, o_rf_raddr);
            void'(sb.pop_front());
          end
        end
      end
      if (o_rf_we) begin
        if (sb.size() == 0 || sb[0].kind != 1) begin
          check({name, "_unexp_rfwe"}, {31'd0, o_rf_we}, 32'd0);
        end else begin
          check({name, "_rfwaddr"}, {28'd0, o_rf_waddr}, {28'd0, sb[0].rg});
          check({name, "_rfwdata"}, o_rf_wdata, sb[0].data);
          check({name, "_rfcyc"}, rel, sb[0].cyc);
          $display("%s: T+%0d rf write r%0d=%h", name, rel, o_rf_waddr, o_rf_wdata);
          void'(sb.pop_front());
        end
      end
      if (o_done) begin
        if (sb.size() == 0 || sb[0].kind != 2) begin
          check({name, "_unexp_done"}, {31'd0, o_done}, 32'd0);
        end else begin
          check({name, "_donecyc"}, rel, sb[0].cyc);
          $display("%s: T+%0d done", name, rel);
          void'(sb.pop_front());
        end
      end
    end
    i_start = 1'b0;
    check({name, "_sb_left"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_reg_list = 16'd0; i_rn_code = 4'd0;
    i_base = 32'd0; i_p = 1'b0; i_u = 1'b0; i_w = 1'b0; i_l = 1'b0; i_mem_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check_idle_outputs("rst");
    check("rst_mem_wdata", o_mem_wdata, rf_val(4'd0));
    $display("reset: outputs idle");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // LDMIA r0!,{r1,r2,r5}
    run_op("ldmia", 16'h0026, 4'd0, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    // STMDB r13!,{r4,r14}, start held high throughout to prove it is ignored
    run_op("stmdb", 16'h4010, 4'd13, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    // LDMDA r2,{r3,r7} with three wait cycles on the first access
    run_op("ldmda", 16'h0088, 4'd2, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    // Empty list with writeback requested
    run_op("empty", 16'h0000, 4'd3, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    // LDMIB r0!,{r0} wrapping past 2^32
    run_op("wrap", 16'h0001, 4'd0, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);

    // Reset during the second access of LDMIA r8,{r1-r4}
    @(negedge i_clk);
    i_start = 1'b1; i_reg_list = 16'h001E; i_rn_code = 4'd8; i_base = 32'h0000_4000;
    i_p = 1'b0; i_u = 1'b1; i_w = 1'b0; i_l = 1'b1; i_mem_ack = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    check("rstop_addr1", o_mem_addr, 32'h0000_4000);
    @(negedge i_clk);
    i_rst_n = 1'b0; i_mem_ack = 1'b0;
    #1;
    check("rstop_addr2", o_mem_addr, 32'h0000_4004);
    $display("rstop: reset asserted during access at %h", o_mem_addr);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_mem_ack = 1'b1;
    #1;
    check_idle_outputs("rstop");
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      #1;
      check("rstop_quiet", {29'd0, o_mem_req, o_rf_we, o_done}, 32'd0);
    end

    // Normal operation after reset; STMIA r5!,{r0,r5,r15} stores original r5
    run_op("stmia", 16'h8021, 4'd5, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    // LDMDB r9!,{r15} loads PC as an ordinary RF write, with one wait cycle
    run_op("ldmpc", 16'h8000, 4'd9, 32'h0000_0800, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
